// File: rtl/z80_ret_seq.sv
// Z80 RET / RET cc / RETI / RETN sequencer: checks the condition, pops the return PC over a byte-wide req/ack port.
// Optional macro Z80_RET_RETN_EN: RETN copies the captured IFF2 into IFF1 on completion.
module z80_ret_seq #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [2:0]            cc,
    input  logic [7:0]            flags,
    input  logic [ADDR_WIDTH-1:0] sp_in,
    input  logic [ADDR_WIDTH-1:0] pc_next_in,
    input  logic                  iff2_in,
    output logic                  busy,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic                  done,
    output logic                  taken,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] sp_out,
    output logic                  reti_out,
    output logic                  iff_we,
    output logic                  iff1_out
);
    localparam int NB = ADDR_WIDTH / 8;
    localparam logic [2:0]            IDX_LAST = 3'(NB - 1);
    localparam logic [ADDR_WIDTH-1:0] NB_W     = ADDR_WIDTH'(NB);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [2:0]            cc_q, cc_d;
    logic [3:0]            flg_q, flg_d;      // {S, Z, P/V, C}
    logic [ADDR_WIDTH-1:0] sp_q, sp_d;
    logic [ADDR_WIDTH-1:0] pcn_q, pcn_d;
    logic [2:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] acc_q, acc_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
    logic [ADDR_WIDTH-1:0] sp_out_q, sp_out_d;
    logic                  taken_q, taken_d;
`ifdef Z80_RET_RETN_EN
    logic                  iff2_q, iff2_d;
`endif

    logic flag_bit;
    logic cond;

    // cc[2:1] selects the flag, cc[0] selects the polarity (odd codes test for set)
    always_comb begin
        flag_bit = 1'b0;
        case (cc_q[2:1])
            2'd0:    flag_bit = flg_q[2];
            2'd1:    flag_bit = flg_q[0];
            2'd2:    flag_bit = flg_q[1];
            default: flag_bit = flg_q[3];
        endcase
        cond = (mode_q != 2'd1) || (cc_q[0] ? flag_bit : !flag_bit);
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cc_d     = cc_q;
        flg_d    = flg_q;
        sp_d     = sp_q;
        pcn_d    = pcn_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        pc_out_d = pc_out_q;
        sp_out_d = sp_out_q;
        taken_d  = taken_q;
`ifdef Z80_RET_RETN_EN
        iff2_d   = iff2_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    cc_d    = cc;
                    flg_d   = {flags[7], flags[6], flags[2], flags[0]};
                    sp_d    = sp_in;
                    pcn_d   = pc_next_in;
`ifdef Z80_RET_RETN_EN
                    iff2_d  = iff2_in;
`endif
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                idx_d = 3'd0;
                if (cond) begin
                    state_d = S_READ;
                end else begin
                    state_d  = S_DONE;
                    taken_d  = 1'b0;
                    pc_out_d = pcn_q;
                    sp_out_d = sp_q;
                end
            end
            S_READ: begin
                if (mem_ack) begin
                    acc_d[8*idx_q +: 8] = mem_rdata;
                    if (idx_q == IDX_LAST) begin
                        state_d  = S_DONE;
                        taken_d  = 1'b1;
                        pc_out_d = acc_d;
                        sp_out_d = sp_q + NB_W;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            cc_q     <= '0;
            flg_q    <= '0;
            sp_q     <= '0;
            pcn_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            pc_out_q <= '0;
            sp_out_q <= '0;
            taken_q  <= 1'b0;
`ifdef Z80_RET_RETN_EN
            iff2_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cc_q     <= cc_d;
            flg_q    <= flg_d;
            sp_q     <= sp_d;
            pcn_q    <= pcn_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            pc_out_q <= pc_out_d;
            sp_out_q <= sp_out_d;
            taken_q  <= taken_d;
`ifdef Z80_RET_RETN_EN
            iff2_q   <= iff2_d;
`endif
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign mem_req  = (state_q == S_READ);
    assign mem_addr = mem_req ? (sp_q + ADDR_WIDTH'(idx_q)) : '0;
    assign done     = (state_q == S_DONE);
    assign taken    = taken_q;
    assign pc_out   = pc_out_q;
    assign sp_out   = sp_out_q;
    assign reti_out = done && taken_q && (mode_q == 2'd2);
`ifdef Z80_RET_RETN_EN
    assign iff_we   = done && taken_q && (mode_q == 2'd3);
    assign iff1_out = iff_we && iff2_q;
`else
    assign iff_we   = 1'b0;
    assign iff1_out = 1'b0;
`endif
endmodule
